// File: rtl/mult_div_if.sv
// Start/busy/done handshake between the pipeline and the multiply/divide unit,
// plus the MTHI/MTLO write port and the architectural HI/LO read-back.
interface mult_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO registers.
// One shift-add or restoring-divide step per clock, followed by a sign-fix cycle.
module mult_div #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input logic       clk,
  input logic       rst,
  mult_div_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    acc;
  logic [WIDTH:0]   rem;
  logic [CNT_W-1:0] count;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Operand capture: signed ops latch magnitudes, unsigned ops latch raw values
  logic             in_signed;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  assign in_signed = ~bus.op[0];
  assign abs_a = (in_signed && bus.a[WIDTH-1]) ? (-bus.a) : bus.a;
  assign abs_b = (in_signed && bus.b[WIDTH-1]) ? (-bus.b) : bus.b;

  // One iteration step for each algorithm
  logic [PW-1:0]    partial;
  logic [CNT_W-1:0] div_idx;
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;
  logic             q_bit;
  assign partial = {WIDTH'(0), mag_a} << count;
  assign div_idx = CNT_W'(WIDTH - 1) - count;
  assign rem_sh  = {rem, mag_a[div_idx]};
  assign trial   = rem_sh - {2'b00, mag_b};
  assign q_bit   = ~trial[WIDTH+1];

  // Sign correction applied in FIX
  logic             is_signed;
  logic             neg_res;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] a_orig;
  assign is_signed = ~op_q[0];
  assign neg_res   = is_signed & (sign_a ^ sign_b);
  assign prod_fix  = neg_res ? (-acc) : acc;
  assign quot_fix  = neg_res ? (-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
  assign rem_fix   = (is_signed && sign_a) ? (-rem[WIDTH-1:0]) : rem[WIDTH-1:0];
  assign a_orig    = (is_signed && sign_a) ? (-mag_a) : mag_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= 2'b00;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      rem    <= '0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // start takes priority over a same-cycle MTHI/MTLO
          if (bus.start) begin
            op_q   <= bus.op;
            sign_a <= in_signed & bus.a[WIDTH-1];
            sign_b <= in_signed & bus.b[WIDTH-1];
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            acc    <= '0;
            rem    <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            if (bus.wr_hi) hi_q <= bus.wdata;
            if (bus.wr_lo) lo_q <= bus.wdata;
          end
        end
        RUN: begin
          count <= count + CNT_W'(1);
          if (op_q[1]) begin
            rem <= q_bit ? trial[WIDTH:0] : rem_sh[WIDTH:0];
            acc <= {acc[PW-2:0], q_bit};
          end else if (mag_b[count]) begin
            acc <= acc + partial;
          end
          if (count == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (!op_q[1]) begin
            hi_q <= prod_fix[PW-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (mag_b == '0) begin
            hi_q <= a_orig;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div.sv
// Randomized bench for mult_div: a cycle-level reference model built from 64-bit
// arithmetic is compared with the DUT every cycle, plus literal directed cases.
module tb_mult_div;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_div_if #(.WIDTH(W)) bus ();
  mult_div #(.WIDTH(W), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi, lo} of one operation, from plain arithmetic
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Cycle model: a request accepted when idle delivers its result 33 edges later
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [63:0] m_res = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else if (m_busy) begin
      m_left--;
      m_done = 1'b0;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_hi = m_res[63:32];
        m_lo = m_res[31:0];
      end
    end else begin
      m_done = 1'b0;
      if (bus.start) begin
        m_res = ref_op(bus.op, bus.a, bus.b);
        m_busy = 1'b1;
        m_left = 33;
      end else begin
        if (bus.wr_hi) m_hi = bus.wdata;
        if (bus.wr_lo) m_lo = bus.wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    bus.op = 2'($urandom_range(0, 3)); bus.a = $urandom; bus.b = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) chk("done_timeout", 32'(bus.done), 32'h1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, dseen;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy_early", 32'(bus.busy), 32'h1);
    wait_done(n);
    chk("multu_latency", 32'(n), 32'd33);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    chk("multu_busy_done", 32'(bus.busy), 32'h0);
    @(negedge clk);

    issue(2'b00, 32'hFFFF_FFF9, 32'd6);
    wait_done(n);
    chk("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", bus.lo, 32'hFFFF_FFD6);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done(n);
    chk("b2b_spacing", 32'(n + 1), 32'd34);
    chk("mult_min_hi", bus.hi, 32'h4000_0000);
    chk("mult_min_lo", bus.lo, 32'h0);
    @(negedge clk);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
    issue(2'b11, 32'd100000, 32'd10001);
    wait_done(n);
    chk("divu_lo", bus.lo, 32'd9);
    chk("divu_hi", bus.hi, 32'd9991);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    chk("div_ovf_lo", bus.lo, 32'h8000_0000);
    chk("div_ovf_hi", bus.hi, 32'h0);
    issue(2'b11, 32'h1234, 32'h0);
    wait_done(n);
    chk("div0_latency", 32'(n + 1), 32'd34);
    chk("div0_hi", bus.hi, 32'h1234);
    chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
    @(negedge clk);

    bus.wr_hi = 1'b1; bus.wdata = 32'hAAAA_0000;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    chk("mthi", bus.hi, 32'hAAAA_0000);
    issue(2'b01, 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd7; bus.b = 32'd9;
    bus.wr_lo = 1'b1; bus.wdata = 32'h5555_5555;
    @(negedge clk);
    bus.start = 1'b0; bus.wr_lo = 1'b0;
    wait_done(n);
    chk("ign_hi", bus.hi, 32'h0);
    chk("ign_lo", bus.lo, 32'd15);
    dseen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dseen++;
    end
    chk("ign_single_done", 32'(dseen), 32'd0);

    issue(2'b10, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    chk("abort_hi", bus.hi, 32'h0);
    chk("abort_lo", bus.lo, 32'h0);
    dseen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dseen++;
    end
    chk("abort_no_done", 32'(dseen), 32'd0);
    issue(2'b01, 32'd2, 32'd3);
    wait_done(n);
    chk("post_rst_latency", 32'(n), 32'd33);
    chk("post_rst_lo", bus.lo, 32'd6);
    @(negedge clk);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.wr_hi = 1'($urandom_range(0, 1)); bus.wr_lo = 1'b1; bus.wdata = $urandom;
        @(negedge clk);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
      end
      bus.wr_hi = 1'($urandom_range(0, 1)); bus.wdata = $urandom;
      issue(2'($urandom_range(0, 3)), pick(), pick());
      for (int j = 0; j < int'($urandom_range(0, 30)); j++) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.wr_hi = 1'($urandom_range(0, 1));
        bus.wr_lo = 1'($urandom_range(0, 1));
        bus.wdata = $urandom;
        @(negedge clk);
      end
      bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
      wait_done(n);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
